seq_divider: RTL and testbench

- Multi-cycle restoring integer divider for the KGP-miniRISC ALU.
- It is the inverse operation of the registered CLA adder path: quotient bits are produced by repeated CLA-based trial subtraction.
- It sits beside the adder in the ALU and uses a start/busy/done handshake toward the control unit.
- Unsigned by default; signed mode is a compile-time option.

---
 rtl/alu_pkg.sv | 18 +
 rtl/seq_divider_if.sv | 23 ++
 rtl/cla_subtractor.sv | 40 ++++
 rtl/seq_divider.sv | 159 +++++++++++++++
 tb/tb_seq_divider.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default operand width and
// the counter-width helper used by the sequential divider.
package alu_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed for a down-counter that starts at w.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake between the ALU control unit and the divider.
interface seq_divider_if #(
  parameter int WIDTH = alu_pkg::DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/cla_subtractor.sv
// Carry-lookahead subtractor computing a + ~b + 1; carry_out=1 means a >= b.
module cla_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             carry_out
);
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             acc;
  logic             prod;

  assign gen  = a & ~b;
  assign prop = a ^ ~b;

  // Each carry is a flat sum of generate terms; the carry-in is tied to 1.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    carry    = '0;
    acc      = 1'b0;
    prod     = 1'b0;
    carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      acc = 1'b1;
      for (int j = 0; j <= i; j++) acc = acc & prop[j];
      for (int j = 0; j <= i; j++) begin
        prod = gen[j];
        for (int k = j + 1; k <= i; k++) prod = prod & prop[k];
        acc = acc | prod;
      end
      carry[i+1] = acc;
    end
  end

  assign diff      = prop ^ carry[WIDTH-1:0];
  assign carry_out = carry[WIDTH];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for the KGP-miniRISC ALU.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = count_width(WIDTH);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] prem, prem_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] dvsr, dvsr_nxt;
  logic [WIDTH-1:0] quo, quo_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             dbz, dbz_nxt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] q_result;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;

`ifdef SIGNED_DIV_EN
  logic q_neg, q_neg_nxt;
  logic r_neg, r_neg_nxt;

  assign dividend_in = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign divisor_in  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign q_result    = q_neg ? -sreg : sreg;
  assign r_result    = r_neg ? -prem : prem;
`else
  assign dividend_in = bus.dividend;
  assign divisor_in  = bus.divisor;
  assign q_result    = sreg;
  assign r_result    = prem;
`endif

  assign shifted = {prem, sreg[WIDTH-1]};

  cla_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .a         (shifted),
    .b         ({1'b0, dvsr}),
    .diff      (trial),
    .carry_out (no_borrow)
  );

  // The partial remainder stays below the divisor, so a kept trial fits WIDTH bits.
  a_trial_fits: assert property (@(posedge clk) disable iff (!rst)
    no_borrow |-> !trial[WIDTH]);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    prem_nxt  = prem;
    sreg_nxt  = sreg;
    dvsr_nxt  = dvsr;
    quo_nxt   = quo;
    rem_nxt   = rem;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    dbz_nxt   = dbz;
`ifdef SIGNED_DIV_EN
    q_neg_nxt = q_neg;
    r_neg_nxt = r_neg;
`endif
    case (state)
      RUN: begin
        if (count != '0) begin
          prem_nxt  = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          sreg_nxt  = {sreg[WIDTH-2:0], no_borrow};
          count_nxt = count - CW'(1);
          // busy covers the iteration cycles only, not the result-load cycle.
          if (count == CW'(1)) busy_nxt = 1'b0;
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          quo_nxt   = q_result;
          rem_nxt   = r_result;
        end
      end
      default: begin
        state_nxt = IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            quo_nxt   = '1;
            rem_nxt   = bus.dividend;
            dbz_nxt   = 1'b1;
          end else begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
            dbz_nxt   = 1'b0;
            count_nxt = CW'(WIDTH);
            prem_nxt  = '0;
            sreg_nxt  = dividend_in;
            dvsr_nxt  = divisor_in;
`ifdef SIGNED_DIV_EN
            q_neg_nxt = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_nxt = bus.dividend[WIDTH-1];
`endif
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments; all of them, datapath
  // included, are cleared by reset so an aborted division leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      prem   <= '0;
      sreg   <= '0;
      dvsr   <= '0;
      quo    <= '0;
      rem    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz    <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      prem   <= prem_nxt;
      sreg   <= sreg_nxt;
      dvsr   <= dvsr_nxt;
      quo    <= quo_nxt;
      rem    <= rem_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      dbz    <= dbz_nxt;
`ifdef SIGNED_DIV_EN
      q_neg  <= q_neg_nxt;
      r_neg  <= r_neg_nxt;
`endif
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: an edge-indexed reference model checked every cycle,
// directed literal cases, and a randomized start/operand phase.
module tb_seq_divider;
  import alu_pkg::*;

  localparam int W = DIV_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference result {div_by_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
`ifdef SIGNED_DIV_EN
    int sa;
    int sb;
`endif
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SIGNED_DIV_EN
    sa = $signed(a);
    sb = $signed(b);
    q  = W'(sa / sb);
    r  = W'(sa % sb);
`else
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  // Model: timing of each accepted operation expressed in edge numbers.
  int           edge_n;
  int           free_from;
  int           done_edge;
  int           busy_from;
  int           busy_to;
  logic [W-1:0] exp_q;
  logic [W-1:0] exp_r;
  logic         exp_dbz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_n    <= 0;
      free_from <= 0;
      done_edge <= -1;
      busy_from <= 1;
      busy_to   <= 0;
      exp_q     <= '0;
      exp_r     <= '0;
      exp_dbz   <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (bus.start && (edge_n + 1 >= free_from)) begin
        {exp_dbz, exp_q, exp_r} <= ref_div(bus.dividend, bus.divisor);
        if (bus.divisor == '0) begin
          done_edge <= edge_n + 1;
          free_from <= edge_n + 2;
        end else begin
          done_edge <= edge_n + W + 2;
          free_from <= edge_n + W + 3;
          busy_from <= edge_n + 1;
          busy_to   <= edge_n + W;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("done", int'(bus.done), int'(edge_n == done_edge));
    check("busy", int'(bus.busy), int'(edge_n >= busy_from && edge_n <= busy_to));
    check("div_by_zero", int'(bus.div_by_zero), (edge_n >= done_edge) ? int'(exp_dbz) : 0);
    if (edge_n >= done_edge) begin
      check("quotient", int'(bus.quotient), int'(exp_q));
      check("remainder", int'(bus.remainder), int'(exp_r));
    end
  end

  // Called on the falling edge right after the accepting edge.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, busy_cycles);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bsy;
    int seen;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_quotient", int'(bus.quotient), 0);
    check("reset_remainder", int'(bus.remainder), 0);
    rst = 1'b1;

`ifndef SIGNED_DIV_EN
    run_op(4'd13, 4'd3, lat, bsy);
    check("13div3_latency", lat, W + 1);
    check("13div3_busy_cycles", bsy, 4);
    check("13div3_q", int'(bus.quotient), 4);
    check("13div3_r", int'(bus.remainder), 1);
    check("13div3_dbz", int'(bus.div_by_zero), 0);
    run_op(4'd15, 4'd1, lat, bsy);
    check("15div1_q", int'(bus.quotient), 15);
    check("15div1_r", int'(bus.remainder), 0);
    run_op(4'd2, 4'd7, lat, bsy);
    check("2div7_q", int'(bus.quotient), 0);
    check("2div7_r", int'(bus.remainder), 2);
    run_op(4'd15, 4'd15, lat, bsy);
    check("15div15_q", int'(bus.quotient), 1);
    check("15div15_r", int'(bus.remainder), 0);
`else
    run_op(4'b1001, 4'd2, lat, bsy);
    check("m7div2_q", int'(bus.quotient), 4'b1101);
    check("m7div2_r", int'(bus.remainder), 4'b1111);
    run_op(4'd7, 4'b1110, lat, bsy);
    check("7divm2_q", int'(bus.quotient), 4'b1101);
    check("7divm2_r", int'(bus.remainder), 1);
    run_op(4'b1000, 4'b1111, lat, bsy);
    check("m8divm1_q", int'(bus.quotient), 4'b1000);
    check("m8divm1_r", int'(bus.remainder), 0);
`endif

    run_op(4'd9, 4'd0, lat, bsy);
    check("9div0_latency", lat, 0);
    check("9div0_q", int'(bus.quotient), 15);
    check("9div0_r", int'(bus.remainder), 9);
    check("9div0_dbz", int'(bus.div_by_zero), 1);
    run_op(4'd6, 4'd2, lat, bsy);
    check("6div2_q", int'(bus.quotient), 3);
    check("6div2_r", int'(bus.remainder), 0);
    check("6div2_dbz", int'(bus.div_by_zero), 0);

    // Start held high through RUN with changing operands, then reused in DONE.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd7;
    bus.divisor  = 4'd3;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
    end
    check("held_start_latency", lat, W + 1);
    check("held_start_q", int'(bus.quotient), 2);
    check("held_start_r", int'(bus.remainder), 1);
    bus.dividend = 4'd14;
    bus.divisor  = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bsy);
    check("back_to_back_latency", lat, W + 1);
`ifndef SIGNED_DIV_EN
    check("back_to_back_q", int'(bus.quotient), 3);
    check("back_to_back_r", int'(bus.remainder), 2);
`endif

    // Abort after two iterations.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd11;
    bus.divisor  = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("busy_before_abort", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_quotient", int'(bus.quotient), 0);
    check("abort_remainder", int'(bus.remainder), 0);
    check("abort_dbz", int'(bus.div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    run_op(4'd7, 4'd2, lat, bsy);
    check("after_abort_q", int'(bus.quotient), 3);
    check("after_abort_r", int'(bus.remainder), 1);

    // Random starts, including ones that land in RUN and divisors of zero.
    repeat (600) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.dividend = W'($urandom);
      bus.divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
